writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 64-bit RV64I core.
- Captures MEM-stage results and performs load byte/half/word extraction with sign/zero extension.
- Selects the writeback source and drives WriteData/RD/RegWrite straight into the register file write port; the same signals serve as the WB forwarding source.
- Also keeps a retired-instruction counter.

Parameters:
RETIRE_W, 64, width of RetireCount (wraps modulo 2^RETIRE_W)

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
MemValid  input  1  MEM stage holds a valid instruction
Stall  input  1  hold MEM/WB contents this cycle
Flush  input  1  invalidate MEM/WB contents this cycle
ALUResult  input  64  ALU result / load effective address
MemReadData  input  64  raw doubleword from data memory (aligned to address[63:3])
PCPlus4  input  64  return address for jal/jalr
RDIn  input  5  destination register
RegWriteIn  input  1  instruction writes rd
MemtoReg  input  2  00 ALU, 01 load, 10 PC+4, 11 reserved
Funct3  input  3  load size/sign (used only when MemtoReg=01)
WriteData  output  64  to register file WriteData
RD  output  5  to register file RD
RegWrite  output  1  to register file RegWrite
WBValid  output  1  MEM/WB entry valid
RetireCount  output  RETIRE_W  valid instructions accepted into WB

Behaviour:
- Reset (async, active-high):
  - WriteData=0, RD=0, WBValid=0, RegWrite=0, RetireCount=0.
  - Reset asserted mid-stream discards the held entry without waiting for a clock edge.
- Per rising edge, in priority order:
  - Flush=1: WBValid<=0; data/RD registers may hold; counter unchanged. Flush overrides Stall.
  - Stall=1: all registers hold; counter unchanged.
  - Otherwise: WBValid<=MemValid, RD<=RDIn, regwrite flag<=RegWriteIn, WriteData<=selected value; RetireCount+=1 iff MemValid=1.
- Latency: exactly 1 cycle from MEM inputs to WB outputs; no combinational path from inputs to outputs.
- RegWrite output = WBValid & registered RegWriteIn & (RD!=0).
  - Writes to x0 are never issued.
  - A stalled valid entry keeps RegWrite high, re-writing the same value every cycle (idempotent).
- Writeback select, computed before the register:
  - 00 → ALUResult.
  - 01 → extracted load.
  - 10 → PCPlus4.
  - 11 → 64'd0.
- Load extraction: off = ALUResult[2:0], little-endian.
  - 000 lb: byte off, sign-extend.
  - 100 lbu: byte off, zero-extend.
  - 001 lh: halfword at off[2:1], sign-extend.
  - 101 lhu: halfword at off[2:1], zero-extend.
  - 010 lw: word at off[2], sign-extend.
  - 110 lwu: word at off[2], zero-extend.
  - 011 ld: full doubleword.
  - 111: 64'd0.
  - Misaligned low address bits below the access size are ignored.
- RetireCount wraps to 0 after all-ones, no saturation.
- Simultaneous Flush and MemValid: entry dropped and not counted.

Test Plan:
- Reset with RetireCount=5 and WBValid=1, reset pulsed between edges → all outputs 0 immediately; first edge after release with MemValid=1, RDIn=5, MemtoReg=00, ALUResult=0x1234 → WriteData=0x1234, RD=5, RegWrite=1, RetireCount=1.
- Load extraction: MemReadData=0x8877_6655_4433_2281, MemtoReg=01:
  - Funct3=000, off=0 → 0xFFFF_FFFF_FFFF_FF81.
  - Funct3=100, off=0 → 0x81.
  - Funct3=001, off=2 → 0x4433.
  - Funct3=010, off=4 → 0xFFFF_FFFF_8877_6655.
  - Funct3=110, off=4 → 0x8877_6655.
  - Funct3=011 → full value.
- MemtoReg=10, PCPlus4=0x104, RDIn=1 → WriteData=0x104, RegWrite=1. Repeat with RDIn=0 → RegWrite=0 while WBValid=1 and RetireCount still increments.
- Stall for 3 cycles with a valid entry, inputs changing → outputs frozen, RegWrite stays 1, RetireCount unchanged; release → new entry appears next edge.
- Flush and Stall both high with MemValid=1 → WBValid=0, RegWrite=0, counter unchanged.
- RETIRE_W=4, 17 valid accepts → RetireCount=1 (wrap at 16).

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load extraction and writeback-source select.
// Drives the register file write port, doubles as the WB forwarding source and counts retirements.
module writeback_stage #(
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemValid,
    input  logic                Stall,
    input  logic                Flush,
    input  logic [63:0]         ALUResult,
    input  logic [63:0]         MemReadData,
    input  logic [63:0]         PCPlus4,
    input  logic [4:0]          RDIn,
    input  logic                RegWriteIn,
    input  logic [1:0]          MemtoReg,
    input  logic [2:0]          Funct3,
    output logic [63:0]         WriteData,
    output logic [4:0]          RD,
    output logic                RegWrite,
    output logic                WBValid,
    output logic [RETIRE_W-1:0] RetireCount
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] word_sel;
    logic [63:0] load_data;
    logic [63:0] wb_sel;

    logic [63:0]         wdata_q;
    logic [4:0]          rd_q;
    logic                regwrite_q;
    logic                valid_q;
    logic [RETIRE_W-1:0] retire_q;

    // Address bits below the access size are dropped, so misaligned offsets round down.
    assign byte_sel = MemReadData[{ALUResult[2:0], 3'b000} +: 8];
    assign half_sel = MemReadData[{ALUResult[2:1], 4'b0000} +: 16];
    assign word_sel = MemReadData[{ALUResult[2], 5'b00000} +: 32];

    always_comb begin
        load_data = '0;
        case (Funct3)
            3'b000:  load_data = {{56{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {56'd0, byte_sel};
            3'b001:  load_data = {{48{half_sel[15]}}, half_sel};
            3'b101:  load_data = {48'd0, half_sel};
            3'b010:  load_data = {{32{word_sel[31]}}, word_sel};
            3'b110:  load_data = {32'd0, word_sel};
            3'b011:  load_data = MemReadData;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        wb_sel = '0;
        case (MemtoReg)
            2'b00:   wb_sel = ALUResult;
            2'b01:   wb_sel = load_data;
            2'b10:   wb_sel = PCPlus4;
            default: wb_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
            retire_q   <= '0;
        end else if (Flush) begin
            valid_q <= 1'b0;
        end else if (!Stall) begin
            wdata_q    <= wb_sel;
            rd_q       <= RDIn;
            regwrite_q <= RegWriteIn;
            valid_q    <= MemValid;
            if (MemValid) begin
                retire_q <= retire_q + RETIRE_W'(1);
            end
        end
    end

    // x0 is never written; a stalled valid entry keeps re-issuing the same write.
    assign RegWrite    = valid_q & regwrite_q & (rd_q != 5'd0);
    assign WriteData   = wdata_q;
    assign RD          = rd_q;
    assign WBValid     = valid_q;
    assign RetireCount = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed plan cases plus randomized traffic.
// A second instance with a 4-bit retire counter exercises the wrap.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemValid, Stall, Flush, RegWriteIn;
    logic [63:0] ALUResult, MemReadData, PCPlus4;
    logic [4:0]  RDIn;
    logic [1:0]  MemtoReg;
    logic [2:0]  Funct3;

    logic [63:0] WriteData, WriteData4;
    logic [4:0]  RD, RD4;
    logic        RegWrite, RegWrite4, WBValid, WBValid4;
    logic [63:0] RetireCount;
    logic [3:0]  RetireCount4;

    writeback_stage #(.RETIRE_W(64)) dut (
        .clk(clk), .reset(reset), .MemValid(MemValid), .Stall(Stall), .Flush(Flush),
        .ALUResult(ALUResult), .MemReadData(MemReadData), .PCPlus4(PCPlus4),
        .RDIn(RDIn), .RegWriteIn(RegWriteIn), .MemtoReg(MemtoReg), .Funct3(Funct3),
        .WriteData(WriteData), .RD(RD), .RegWrite(RegWrite), .WBValid(WBValid),
        .RetireCount(RetireCount)
    );

    writeback_stage #(.RETIRE_W(4)) dut4 (
        .clk(clk), .reset(reset), .MemValid(MemValid), .Stall(Stall), .Flush(Flush),
        .ALUResult(ALUResult), .MemReadData(MemReadData), .PCPlus4(PCPlus4),
        .RDIn(RDIn), .RegWriteIn(RegWriteIn), .MemtoReg(MemtoReg), .Funct3(Funct3),
        .WriteData(WriteData4), .RD(RD4), .RegWrite(RegWrite4), .WBValid(WBValid4),
        .RetireCount(RetireCount4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        v;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    // reference state: what the WB outputs should be after each edge
    bit        m_v;
    bit [4:0]  m_rd;
    bit        m_rw;
    bit [63:0] m_wd;
    bit [63:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] load_ref(input logic [2:0] f3, input logic [63:0] mem,
                                             input logic [2:0] off);
        int          size;
        int          base;
        logic [63:0] raw;
        logic [63:0] mask;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        base = (int'(off) / size) * size;
        raw  = mem >> (base * 8);
        if (size == 8) return raw;
        mask = (64'd1 << (size * 8)) - 64'd1;
        raw  = raw & mask;
        if (!f3[2] && raw[size*8-1]) raw = raw | ~mask;
        return raw;
    endfunction

    function automatic logic [63:0] sel_ref();
        case (MemtoReg)
            2'd0:    return ALUResult;
            2'd1:    return load_ref(Funct3, MemReadData, ALUResult[2:0]);
            2'd2:    return PCPlus4;
            default: return 64'd0;
        endcase
    endfunction

    task automatic drive(input bit v, input bit [4:0] rdi, input bit rwi, input bit [1:0] m2r,
                         input bit [2:0] f3, input bit [63:0] alu, input bit [63:0] mem,
                         input bit [63:0] pc, input bit st, input bit fl);
        MemValid = v; RDIn = rdi; RegWriteIn = rwi; MemtoReg = m2r; Funct3 = f3;
        ALUResult = alu; MemReadData = mem; PCPlus4 = pc; Stall = st; Flush = fl;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
              $urandom_range(0, 4) != 0, 2'($urandom), 3'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (Flush) begin
            m_v = 0;
        end else if (!Stall) begin
            m_v  = MemValid;
            m_rd = RDIn;
            m_rw = RegWriteIn;
            m_wd = sel_ref();
            if (MemValid) m_cnt = m_cnt + 64'd1;
        end
        sb.push_back('{m_wd, m_rd, m_v && m_rw && (m_rd != 0), m_v, m_cnt});
        #1;
    endtask

    // reset pulsed between clock edges; outputs must clear without an edge
    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_rd", 64'(RD), 64'd0);
        chk("rst_wbvalid", 64'(WBValid), 64'd0);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_count", RetireCount, 64'd0);
        chk("rst_count4", 64'(RetireCount4), 64'd0);
        m_v = 0; m_rd = 0; m_rw = 0; m_wd = 0; m_cnt = 0;
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_wbvalid", 64'(WBValid), 64'(e.v));
            chk("sb_regwrite", 64'(RegWrite), 64'(e.rw));
            chk("sb_count", RetireCount, e.cnt);
            chk("sb_count4", 64'(RetireCount4), 64'(e.cnt[3:0]));
            chk("sb_wbvalid4", 64'(WBValid4), 64'(e.v));
            chk("sb_regwrite4", 64'(RegWrite4), 64'(e.rw));
            if (e.v) begin
                chk("sb_wdata", WriteData, e.wd);
                chk("sb_rd", 64'(RD), 64'(e.rd));
                chk("sb_wdata4", WriteData4, e.wd);
                chk("sb_rd4", 64'(RD4), 64'(e.rd));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] MEMV = 64'h8877_6655_4433_2281;
    logic [2:0]  ld_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b011};
    logic [2:0]  ld_off [6] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd4, 3'd0};
    logic [63:0] ld_exp [6] = '{64'hFFFF_FFFF_FFFF_FF81, 64'h81, 64'h4433,
                                64'hFFFF_FFFF_8877_6655, 64'h8877_6655, MEMV};

    initial begin
        logic [63:0] frozen;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_v = 0; m_rd = 0; m_rw = 0; m_wd = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // build RetireCount=5 with a valid entry, then reset mid-cycle
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd3, 1, 2'd0, 0, 64'(i), 0, 0, 0, 0);
            cycle();
        end
        pulse_reset();

        drive(1, 5'd5, 1, 2'd0, 0, 64'h1234, 0, 0, 0, 0);
        cycle();
        chk("first_wdata", WriteData, 64'h1234);
        chk("first_rd", 64'(RD), 64'd5);
        chk("first_regwrite", 64'(RegWrite), 64'd1);
        chk("first_count", RetireCount, 64'd1);

        for (int i = 0; i < 6; i++) begin
            drive(1, 5'd7, 1, 2'd1, ld_f3[i], 64'h1000 | 64'(ld_off[i]), MEMV, 0, 0, 0);
            cycle();
            chk($sformatf("load_f3_%0d", ld_f3[i]), WriteData, ld_exp[i]);
        end

        drive(1, 5'd1, 1, 2'd2, 0, 64'hDEAD, 0, 64'h104, 0, 0);
        cycle();
        chk("pc4_wdata", WriteData, 64'h104);
        chk("pc4_regwrite", 64'(RegWrite), 64'd1);
        drive(1, 5'd0, 1, 2'd2, 0, 64'hDEAD, 0, 64'h104, 0, 0);
        cycle();
        chk("x0_regwrite", 64'(RegWrite), 64'd0);
        chk("x0_wbvalid", 64'(WBValid), 64'd1);
        chk("x0_count", RetireCount, 64'd9);

        drive(1, 5'd12, 1, 2'd0, 0, 64'hCAFE_F00D, 0, 0, 0, 0);
        cycle();
        frozen = WriteData;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            Stall = 1'b1; Flush = 1'b0;
            cycle();
            chk("stall_wdata", WriteData, 64'hCAFE_F00D);
            chk("stall_rd", 64'(RD), 64'd12);
            chk("stall_regwrite", 64'(RegWrite), 64'd1);
            chk("stall_count", RetireCount, 64'd10);
        end
        drive(1, 5'd13, 1, 2'd0, 0, 64'h55, 0, 0, 0, 0);
        cycle();
        chk("release_wdata", WriteData, 64'h55);
        chk("release_count", RetireCount, 64'd11);

        drive(1, 5'd14, 1, 2'd0, 0, 64'h66, 0, 0, 1, 1);
        cycle();
        chk("flushstall_wbvalid", 64'(WBValid), 64'd0);
        chk("flushstall_regwrite", 64'(RegWrite), 64'd0);
        chk("flushstall_count", RetireCount, 64'd11);

        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 5'(i), 1, 2'd0, 0, 64'(i), 0, 0, 0, 0);
            cycle();
        end
        chk("wrap_count4", 64'(RetireCount4), 64'd1);
        chk("wrap_count64", RetireCount, 64'd17);

        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) pulse_reset();
            drive_rand();
            cycle();
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        if (frozen != 64'hCAFE_F00D) chk("stall_entry", frozen, 64'hCAFE_F00D);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
